vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Purpose : arbitrates one VRAM port between a display fetcher and two requesters;
//           tracks active/vblank state and counts completed frames.
// Latency : grants and mem_* are combinational; read-valid strobes follow a read grant by 1 cycle.
// Backpr. : display always wins; requesters hold their request until gntN, writes may be
//           held off until vertical blanking (ACTIVE_WRITES=0).
// Ports   : clk/rst_n (sync, active-low); vpos/display_on timing; disp_* fetch port;
//           req/we/addr/wdata/gnt/rvalid per requester; mem_* memory port; vblank_start, frame_cnt.
module vram_arbiter #(
  parameter int AW            = 12,
  parameter int DW            = 8,
  parameter int V_DISPLAY     = 480,
  parameter int ACTIVE_WRITES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    vpos,
  input  logic          display_on,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          vblank_start,
  output logic [7:0]    frame_cnt
);

  localparam logic [10:0] VD = 11'(V_DISPLAY);

  typedef enum logic {ACTIVE = 1'b0, VBLANK = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       last_q;        // 1 = requester 1 was granted most recently
  logic       display_on_q;
  logic       elig0, elig1, wr_ok;

  // The state register is the registered vblank condition; it resets to VBLANK
  // so a release during blanking does not look like a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= VBLANK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if ({1'b0, vpos} >= VD) state_d = VBLANK;
    else                    state_d = ACTIVE;
  end

  // Grant and memory-port mux; display has absolute priority.
  always_comb begin
    wr_ok     = (state_q == VBLANK) || (ACTIVE_WRITES != 0);
    elig0     = req0 && (!we0 || wr_ok);
    elig1     = req1 && (!we1 || wr_ok);
    disp_gnt  = disp_req;
    gnt0      = !disp_req && elig0 && (!elig1 || last_q);
    gnt1      = !disp_req && elig1 && (!elig0 || !last_q);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_gnt) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read-valid strobes, round-robin pointer and frame bookkeeping. Reset drops
  // any read-valid still in flight from the cycle before reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_rvalid  <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      last_q       <= 1'b1;
      vblank_start <= 1'b0;
      frame_cnt    <= 8'd0;
      display_on_q <= 1'b0;
    end else begin
      disp_rvalid  <= disp_gnt;
      rvalid0      <= gnt0 && !we0;
      rvalid1      <= gnt1 && !we1;
      if (gnt0)      last_q <= 1'b0;
      else if (gnt1) last_q <= 1'b1;
      vblank_start <= (state_q == ACTIVE) && (state_d == VBLANK);
      if ((state_q == ACTIVE) && (state_d == VBLANK))
        frame_cnt <= frame_cnt + 8'd1;
      display_on_q <= display_on;
    end
  end

  // Read data is routed to the sources outside this block; display_on is
  // kept registered for debug observation only.
  logic unused_sinks;
  assign unused_sinks = ^{mem_rdata, display_on_q};

endmodule
